// File: rtl/approx_error_monitor_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package approx_pkg;

    // Default operand width of the multiplier under characterisation.
    localparam int unsigned WIDTH_DEF = 8;

    // Widest product handled by abs_diff; callers cast to their own width.
    localparam int unsigned MAX_PROD_W = 64;

    // Window-control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Unsigned magnitude of a - b.
    function automatic logic [MAX_PROD_W-1:0] abs_diff(
        input logic [MAX_PROD_W-1:0] a,
        input logic [MAX_PROD_W-1:0] b
    );
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

endpackage

// File: rtl/approx_error_monitor_mult.sv
// Golden unsigned WIDTH x WIDTH multiplier used as the error reference.
module exact_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    // Full-precision product; both operands widened so no bits are lost.
    always_comb begin
        product = PW'(a) * PW'(b);
    end

endmodule

// File: rtl/approx_error_monitor.sv
// Accumulates error statistics of an approximate multiplier over a
// window of 2^SAMPLES_LOG2 samples: error count, summed and worst-case
// error distance against an exact product recomputed here.
module approx_error_monitor
    import approx_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned SAMPLES_LOG2 = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in1,
    input  logic [WIDTH-1:0]                 in2,
    input  logic [2*WIDTH-1:0]               approx_out,
    output logic                             done,
    output logic [SAMPLES_LOG2:0]            err_count,
    output logic [2*WIDTH+SAMPLES_LOG2-1:0]  sum_ed,
    output logic [2*WIDTH-1:0]               max_ed,
    output logic                             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = PW + SAMPLES_LOG2;
    localparam int unsigned CW = SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0] N_SAMPLES = CW'(2 ** SAMPLES_LOG2);

    state_t            state;
    logic [CW-1:0]     sample_cnt;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_in1;
    logic [WIDTH-1:0]  s1_in2;
    logic [PW-1:0]     s1_approx;

    logic [PW-1:0]     exact;
    logic [PW-1:0]     ed;
    logic              handshake;
    logic              clear;

    assign handshake = in_valid & in_ready;
    // A start is honoured only between windows; clears stats on the same edge.
    assign clear     = start & ((state == ST_IDLE) | (state == ST_DONE));

    // Window control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        sample_cnt <= sample_cnt + CW'(1);
                        if (sample_cnt + CW'(1) == N_SAMPLES) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last sample sits in S1 and is accumulated on this edge.
                    if (s1_valid) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // S1: capture the operand/product triple on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_in1    <= '0;
            s1_in2    <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid <= handshake;
            if (handshake) begin
                s1_in1    <= in1;
                s1_in2    <= in2;
                s1_approx <= approx_out;
            end
        end
    end

    exact_multiplier #(
        .WIDTH (WIDTH)
    ) u_exact_multiplier (
        .a       (s1_in1),
        .b       (s1_in2),
        .product (exact)
    );

    // S2: error distance between the golden and approximate products.
    always_comb begin
        ed = PW'(abs_diff(MAX_PROD_W'(exact), MAX_PROD_W'(s1_approx)));
    end

    // S2: statistics accumulators, cleared when a new window opens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (clear) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (s1_valid) begin
            err_count <= err_count + CW'(ed != '0);
            sum_ed    <= sum_ed + SW'(ed);
            if (ed > max_ed) begin
                max_ed <= ed;
            end
        end
    end

endmodule
